// File: rtl/alu_pkg.sv
// alu_pkg: shared width default, op encodings and the status-flag bundle for the tp4 ALU.
package alu_pkg;
    localparam int DATA_WIDTH = 16;
    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;
    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } alu_flags_t;
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational adder; inv_b inverts b and injects carry-in so a + ~b + 1 yields a - b.
module alu_addsub #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  inv_b,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  ovf
);
    logic [DATA_WIDTH-1:0] w_b;

    assign w_b = inv_b ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, w_b} + {{DATA_WIDTH{1'b0}}, inv_b};
    // Signed overflow: both effective operands share a sign that the result does not.
    assign ovf = (a[DATA_WIDTH-1] == w_b[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
endmodule

// File: rtl/alu.sv
// alu: registered 16-bit add/subtract with one-cycle latency and a valid strobe.
// Define ALU_FLAGS_EN to add registered zero/negative/carry/overflow outputs.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  op,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic                  zero,
    output logic                  negative,
    output logic                  carry,
    output logic                  overflow
`endif
);
    logic                  w_sub;
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_cout;
    logic                  w_ovf;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    assign w_sub = (op == ALU_OP_SUB);

    alu_addsub #(.DATA_WIDTH(DATA_WIDTH)) u_addsub (
        .a     (a),
        .b     (b),
        .inv_b (w_sub),
        .sum   (w_sum),
        .cout  (w_cout),
        .ovf   (w_ovf)
    );

`ifdef ALU_FLAGS_EN
    alu_flags_t r_flags;
    alu_flags_t w_flags;

    // Subtract reports borrow, which is the inverse of the adder carry-out.
    assign w_flags = '{zero:     (w_sum == '0),
                       negative: w_sum[DATA_WIDTH-1],
                       carry:    w_sub ? ~w_cout : w_cout,
                       overflow: w_ovf};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (in_valid) begin
            r_flags <= w_flags;
        end
    end

    assign zero     = r_flags.zero;
    assign negative = r_flags.negative;
    assign carry    = r_flags.carry;
    assign overflow = r_flags.overflow;
`else
    logic w_unused;
    assign w_unused = w_cout ^ w_ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data <= w_sum;
            end
        end
    end

    assign data_out  = r_data;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and random checks of alu against an arithmetic reference model.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu;
    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        in_valid;
    logic [15:0] data_out;
    logic        out_valid;
`ifdef ALU_FLAGS_EN
    logic        zero, negative, carry, overflow;
`endif

    int tests;
    int fails;

    logic [15:0] exp_data;
    logic        exp_valid;
    logic [3:0]  exp_flags;

    alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .op        (op),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
        ,
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"}, data_out, exp_data);
        check({tag, ".valid"}, {15'd0, out_valid}, {15'd0, exp_valid});
`ifdef ALU_FLAGS_EN
        check({tag, ".flags"}, {12'd0, zero, negative, carry, overflow}, {12'd0, exp_flags});
`endif
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
    task automatic model(input logic v, input logic [15:0] ma, input logic [15:0] mb, input logic mop);
        int s;
        int sr;
        logic [15:0] r;
        exp_valid = v;
        if (v) begin
            s  = mop ? int'(ma) - int'(mb) : int'(ma) + int'(mb);
            sr = mop ? int'($signed(ma)) - int'($signed(mb)) : int'($signed(ma)) + int'($signed(mb));
            r  = s[15:0];
            exp_data  = r;
            exp_flags = {r == 16'd0, r[15], mop ? (ma < mb) : (s > 65535), (sr > 32767) || (sr < -32768)};
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [15:0] sa, input logic [15:0] sb, input logic sop);
        @(negedge clk);
        in_valid = v;
        a = sa;
        b = sb;
        op = sop;
        @(posedge clk);
        model(v, sa, sb, sop);
        #1;
        check_all(tag);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_data = 16'd0;
        exp_valid = 1'b0;
        exp_flags = 4'd0;
        rst_n = 1'b0;
        a = 16'd5;
        b = 16'd3;
        op = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;

        step("add_5_3", 1'b1, 16'd5, 16'd3, 1'b0);
        check("add_5_3.lit", data_out, 16'd8);
        step("sub_5_3", 1'b1, 16'd5, 16'd3, 1'b1);
        check("sub_5_3.lit", data_out, 16'd2);
        step("wrap_add", 1'b1, 16'hFFFF, 16'd1, 1'b0);
        check("wrap_add.lit", data_out, 16'h0000);
        step("wrap_sub", 1'b1, 16'd3, 16'd5, 1'b1);
        check("wrap_sub.lit", data_out, 16'hFFFE);
        step("ovf_add", 1'b1, 16'h7FFF, 16'd1, 1'b0);
        check("ovf_add.lit", data_out, 16'h8000);
        step("ovf_sub", 1'b1, 16'h8000, 16'd1, 1'b1);
        check("ovf_sub.lit", data_out, 16'h7FFF);
`ifdef ALU_FLAGS_EN
        check("ovf_sub.overflow", {15'd0, overflow}, 16'd1);
`endif

        step("hold_src", 1'b1, 16'd5, 16'd3, 1'b0);
        step("hold_1", 1'b0, 16'd9, 16'd9, 1'b1);
        check("hold_1.lit", data_out, 16'd8);
        step("hold_2", 1'b0, 16'd1, 16'd2, 1'b0);
        check("hold_2.lit", {15'd0, out_valid}, 16'd0);

        step("stream_0", 1'b1, 16'd1, 16'd1, 1'b0);
        check("stream_0.lit", data_out, 16'd2);
        step("stream_1", 1'b1, 16'd4, 16'd1, 1'b1);
        check("stream_1.lit", data_out, 16'd3);
        step("stream_2", 1'b1, 16'd0, 16'd0, 1'b0);
        check("stream_2.lit", data_out, 16'd0);
        step("stream_3", 1'b1, 16'h1234, 16'h0F0F, 1'b0);
        check("stream_3.lit", data_out, 16'h2143);

        for (int i = 0; i < 60; i++) begin
            step("random", ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom));
        end

        step("pre_midreset", 1'b1, 16'h00F0, 16'h000F, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_data = 16'd0;
        exp_valid = 1'b0;
        exp_flags = 4'd0;
        check_all("midreset");
        check("midreset.lit", data_out, 16'd0);
        @(posedge clk);
        #1;
        check_all("midreset_edge");
        @(negedge clk);
        rst_n = 1'b1;
        step("after_reset", 1'b1, 16'd10, 16'd4, 1'b1);
        check("after_reset.lit", data_out, 16'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
